// File: rtl/mips_defs_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit:
// op encodings, FSM states and datapath widths.
package mips_defs_pkg;

  localparam int XLEN      = 32;
  localparam int PROD_W    = 64;
  localparam int DIV_STEPS = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101,
    MD_MADD  = 3'b110,
    MD_MSUB  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } md_state_e;

  function automatic logic [XLEN-1:0] neg_if(
    input logic            neg,
    input logic [XLEN-1:0] v
  );
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// 32-step restoring radix-2 divider on unsigned magnitudes.
// valid pulses for one cycle after the final step.
module div_radix2
  import mips_defs_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem,
  output logic            valid
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            run_q, run_d;

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] sub;
  logic            ge;
  logic            last;

  assign last  = run_q && (cnt_q == 6'(DIV_STEPS));
  assign valid = last;
  assign quot  = quo_q;
  assign rem   = rem_q;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    ge      = shifted >= {1'b0, dvs_q};
    // true difference is below 2^32 whenever ge holds
    sub     = shifted[XLEN-1:0] - dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (kill) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (last) begin
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q + 6'd1;
      if (ge) begin
        rem_d = sub;
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS32 HI/LO multiply/divide unit with FSM and architectural HI/LO.
// MULDIV_MADD_EN enables MADD/MSUB (ops 110/111).
module muldiv_unit
  import mips_defs_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e state_q, state_d;
  md_op_e    op_q, op_d, op_in;

  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic            done_q, done_d;

  logic              op_ok;
  logic              accept;
  logic              div_start;
  logic              div_sgn_in;
  logic [XLEN-1:0]   div_a_abs;
  logic [XLEN-1:0]   div_b_abs;
  logic [XLEN-1:0]   div_quot;
  logic [XLEN-1:0]   div_rem;
  logic              div_valid;
  logic              mul_sgn;
  logic [PROD_W-1:0] mul_ea;
  logic [PROD_W-1:0] mul_eb;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] mul_res;
  logic              q_neg;
  logic              r_neg;
  logic [PROD_W-1:0] div_res;

  assign op_in = md_op_e'(op);
`ifdef MULDIV_MADD_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = (op_in != MD_MADD) && (op_in != MD_MSUB);
`endif
  assign accept = start && (state_q == ST_IDLE) && !flush && op_ok;

  assign div_sgn_in = (op_in == MD_DIV);
  assign div_a_abs  = neg_if(div_sgn_in & src_a[XLEN-1], src_a);
  assign div_b_abs  = neg_if(div_sgn_in & src_b[XLEN-1], src_b);
  assign div_start  = accept && ((op_in == MD_DIV) || (op_in == MD_DIVU));

  div_radix2 u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .kill     (flush),
    .dividend (div_a_abs),
    .divisor  (div_b_abs),
    .quot     (div_quot),
    .rem      (div_rem),
    .valid    (div_valid)
  );

  // MULTU is the only unsigned multiply-type op
  assign mul_sgn = (op_q != MD_MULTU);
  assign mul_ea  = {{XLEN{mul_sgn & opa_q[XLEN-1]}}, opa_q};
  assign mul_eb  = {{XLEN{mul_sgn & opb_q[XLEN-1]}}, opb_q};
  assign prod    = mul_ea * mul_eb;

  always_comb begin
`ifdef MULDIV_MADD_EN
    unique case (op_q)
      MD_MADD: mul_res = {hi_q, lo_q} + prod;
      MD_MSUB: mul_res = {hi_q, lo_q} - prod;
      default: mul_res = prod;
    endcase
`else
    mul_res = prod;
`endif
  end

  assign q_neg = (op_q == MD_DIV) & (opa_q[XLEN-1] ^ opb_q[XLEN-1]);
  assign r_neg = (op_q == MD_DIV) & opa_q[XLEN-1];

  always_comb begin
    if (opb_q == '0) begin
      div_res = {opa_q, 32'hFFFF_FFFF};
    end else begin
      div_res = {neg_if(r_neg, div_rem), neg_if(q_neg, div_quot)};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = op_in;
          opa_d = src_a;
          opb_d = src_b;
          cnt_d = '0;
          unique case (op_in)
            MD_MTHI: hi_d = src_a;
            MD_MTLO: lo_d = src_a;
            MD_DIV, MD_DIVU: state_d = ST_DIV;
            MD_MULT, MD_MULTU, MD_MADD, MD_MSUB: state_d = ST_MUL;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 6'(MUL_CYCLES - 1)) begin
          {hi_d, lo_d} = mul_res;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(DIV_STEPS - 1)) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush && div_valid) begin
          {hi_d, lo_d} = div_res;
          done_d       = 1'b1;
          cnt_d        = cnt_q + 6'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= MD_MULT;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
